// File: rtl/proc_op_pkg.sv
// Shared opcode and response encodings for the processor op sequencer.
// Decoder opcodes follow the 3-bit binary_in map; 6 and 7 are reserved.
package proc_op_pkg;

    typedef enum logic [2:0] {
        OP_RESET     = 3'd0,
        OP_WD_WRITE  = 3'd1,
        OP_WD_READ   = 3'd2,
        OP_RAM_WRITE = 3'd3,
        OP_MEM_WRITE = 3'd4,
        OP_MEM_READ  = 3'd5,
        OP_RSV6      = 3'd6,
        OP_RSV7      = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        RSP_OK      = 2'd0,
        RSP_TIMEOUT = 2'd1,
        RSP_ILLEGAL = 2'd2
    } rsp_status_e;

    function automatic logic is_read(op_e op);
        return (op == OP_WD_READ) || (op == OP_MEM_READ);
    endfunction

endpackage

// File: rtl/op_timeout_timer.sv
// Saturating wait-cycle counter; expired flags the last allowed wait cycle.
// Counter stops at TIMEOUT so it can never wrap back into range.
module op_timeout_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != TW'(TIMEOUT))) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/op_sequencer.sv
// Issues one decoder operation per command, waits for the target ack
// (bounded by TIMEOUT) and returns status/read data on a response channel.
module op_sequencer
    import proc_op_pkg::*;
#(
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [DW-1:0] cmd_data,
    output logic [2:0]    op_code,
    output logic          op_en,
    output logic [DW-1:0] op_wdata,
    input  logic          op_ack,
    input  logic [DW-1:0] op_rdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [1:0]    rsp_status,
    output logic [DW-1:0] rsp_data,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_RESP
    } state_e;

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [DW-1:0] wdata_q, wdata_d;
    rsp_status_e   status_q, status_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          tmr_clr;
    logic          tmr_en;
    logic          tmr_expired;

    op_timeout_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        wdata_d  = wdata_q;
        status_d = status_q;
        rdata_d  = rdata_q;
        tmr_clr  = 1'b1;
        tmr_en   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d     = op_e'(cmd_op);
                    wdata_d  = cmd_data;
                    rdata_d  = '0;
                    status_d = RSP_OK;
                    if (cmd_op >= 3'd6) begin
                        status_d = RSP_ILLEGAL;
                        state_d  = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (op_q == OP_RESET) begin
                    state_d = S_RESP;
                end else if (op_ack) begin
                    rdata_d = is_read(op_q) ? op_rdata : '0;
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                tmr_clr = 1'b0;
                tmr_en  = 1'b1;
                // Ack takes priority over a coincident timeout.
                if (op_ack) begin
                    rdata_d = is_read(op_q) ? op_rdata : '0;
                    state_d = S_RESP;
                end else if (tmr_expired) begin
                    status_d = RSP_TIMEOUT;
                    rdata_d  = '0;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    op_d     = OP_RESET;
                    wdata_d  = '0;
                    status_d = RSP_OK;
                    rdata_d  = '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_RESET;
            wdata_q  <= '0;
            status_q <= RSP_OK;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            wdata_q  <= wdata_d;
            status_q <= status_d;
            rdata_q  <= rdata_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign op_en      = (state_q == S_ISSUE);
    assign op_code    = op_q;
    assign op_wdata   = wdata_q;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_status = status_q;
    assign rsp_data   = rdata_q;

endmodule

// File: tb/tb_op_sequencer.sv
// Scoreboard bench for op_sequencer: a scripted target acks after a set
// delay; expected responses are queued at issue and popped at handshake.
module tb_op_sequencer;

    localparam int DW      = 8;
    localparam int TIMEOUT = 16;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [DW-1:0] cmd_data;
    logic [2:0]    op_code;
    logic          op_en;
    logic [DW-1:0] op_wdata;
    logic          op_ack;
    logic [DW-1:0] op_rdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_status;
    logic [DW-1:0] rsp_data;
    logic          busy;

    typedef struct {
        logic [1:0]    status;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk;
    int   n_pass;

    op_sequencer #(
        .DW     (DW),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .op_code   (op_code),
        .op_en     (op_en),
        .op_wdata  (op_wdata),
        .op_ack    (op_ack),
        .op_rdata  (op_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_status(rsp_status),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_op_en"}, 32'(op_en), 32'd0);
        chk({tag, "_op_code"}, 32'(op_code), 32'd0);
        chk({tag, "_op_wdata"}, 32'(op_wdata), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_status"}, 32'(rsp_status), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    endtask

    // ack_dly < 0: target never acks; 0: ack in the op_en cycle.
    task automatic run_cmd(input string tag, input logic [2:0] op,
                           input logic [DW-1:0] wd, input int ack_dly,
                           input logic [DW-1:0] rd, input logic [1:0] e_st,
                           input logic [DW-1:0] e_dat, input int e_lat,
                           input int hold);
        exp_t e;
        int   k;
        int   en_cnt;
        int   exp_en;
        bit   done;
        e.status = e_st;
        e.data   = e_dat;
        exp_q.push_back(e);
        exp_en = (op >= 3'd6) ? 0 : 1;
        @(negedge clk);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = wd;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = '0;
        k      = 1;
        en_cnt = 0;
        done   = 1'b0;
        while (!done && k < 60) begin
            if (rsp_valid) begin
                op_ack   = 1'b0;
                op_rdata = 8'hEE;
                chk({tag, "_latency"}, 32'(k), 32'(e_lat));
                chk({tag, "_op_en_pulses"}, 32'(en_cnt), 32'(exp_en));
                for (int h = 0; h < hold; h++) begin
                    chk({tag, "_hold_status"}, 32'(rsp_status),
                        32'(exp_q[0].status));
                    chk({tag, "_hold_data"}, 32'(rsp_data),
                        32'(exp_q[0].data));
                    @(negedge clk);
                end
                rsp_ready = 1'b1;
                e = exp_q.pop_front();
                chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
                chk({tag, "_status"}, 32'(rsp_status), 32'(e.status));
                chk({tag, "_data"}, 32'(rsp_data), 32'(e.data));
                @(posedge clk);
                @(negedge clk);
                rsp_ready = 1'b0;
                chk({tag, "_idle_ready"}, 32'(cmd_ready), 32'd1);
                chk({tag, "_idle_code"}, 32'(op_code), 32'd0);
                done = 1'b1;
            end else begin
                if (op_en) begin
                    en_cnt++;
                    chk({tag, "_op_code"}, 32'(op_code), 32'(op));
                    chk({tag, "_op_wdata"}, 32'(op_wdata), 32'(wd));
                end
                op_ack   = (ack_dly >= 0) && (k == 1 + ack_dly);
                op_rdata = op_ack ? rd : 8'hEE;
                @(negedge clk);
                k++;
            end
        end
        if (!done) begin
            chk({tag, "_rsp_seen"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
        op_ack = 1'b0;
    endtask

    task automatic run_abort();
        int seen;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'd1;
        cmd_data  = 8'h77;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        chk("abort_wdata_before", 32'(op_wdata), 32'h77);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("abort_no_rsp", 32'(seen), 32'd0);
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = '0;
        op_ack    = 1'b0;
        op_rdata  = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd("mem_rd", 3'd5, 8'h00, 3, 8'hA5, 2'd0, 8'hA5, 5, 0);
        run_cmd("ram_wr", 3'd3, 8'h3C, 0, 8'h5A, 2'd0, 8'h00, 2, 0);
        run_cmd("wd_wr_to", 3'd1, 8'h11, -1, 8'h00, 2'd1, 8'h00, 18, 0);
        run_cmd("wd_rd_last", 3'd2, 8'h00, 16, 8'h5C, 2'd0, 8'h5C, 18, 0);
        run_cmd("wd_rd_imm", 3'd2, 8'h00, 0, 8'h81, 2'd0, 8'h81, 2, 2);
        run_cmd("ill6", 3'd6, 8'h99, 0, 8'h42, 2'd2, 8'h00, 1, 0);
        run_cmd("ill7", 3'd7, 8'h00, -1, 8'h00, 2'd2, 8'h00, 1, 0);
        run_cmd("op_reset", 3'd0, 8'h00, -1, 8'h00, 2'd0, 8'h00, 2, 0);
        run_cmd("mem_wr_to", 3'd4, 8'hF0, -1, 8'h00, 2'd1, 8'h00, 18, 1);
        run_cmd("mem_rd_hold", 3'd5, 8'h00, 1, 8'hC3, 2'd0, 8'hC3, 3, 5);
        run_abort();
        run_cmd("post_abort", 3'd3, 8'h6D, 2, 8'h00, 2'd0, 8'h00, 4, 0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
